// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter
//   Shares the physical cartridge bus between the Game Boy core and a host
//   (PS-side) requester. A slot lasts four clocks. The owner of each slot is
//   decided on the clock where the core reports T-cycle 0. The core always
//   wins. The host gets the slot when the core is not asking for it.
//
// Ports
//   clock, reset          : 4.194 MHz T-cycle clock, synchronous active-high reset
//   gb_tCycle             : core T-cycle index 0..3
//   gb_enable/write/chipSelect, gb_address, gb_dataWrite : core request
//   gb_dataRead           : read data returned to the core
//   host_req/write/chipSelect, host_address, host_wdata  : host request
//   host_ack, host_rdata  : host completion pulse and captured read data
//   cart_A, cart_D_in/out, cart_D_oe, cart_nRD/nWR/nCS   : cartridge pins
//   slot_owner            : debug (0 idle, 1 core, 2 host)
module cart_bus_arbiter #(
  parameter int WR_FIRST = 1,
  parameter int WR_LAST  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  gb_tCycle,
  input  logic        gb_enable,
  input  logic        gb_write,
  input  logic        gb_chipSelect,
  input  logic [15:0] gb_address,
  input  logic [7:0]  gb_dataWrite,
  output logic [7:0]  gb_dataRead,
  input  logic        host_req,
  input  logic        host_write,
  input  logic        host_chipSelect,
  input  logic [15:0] host_address,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] cart_A,
  input  logic [7:0]  cart_D_in,
  output logic [7:0]  cart_D_out,
  output logic        cart_D_oe,
  output logic        cart_nRD,
  output logic        cart_nWR,
  output logic        cart_nCS,
  output logic [1:0]  slot_owner
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic        cs;
    logic [7:0]  wdata;
  } req_t;

  // Bit k is set when slot phase k lies within [lo, hi].
  function automatic logic [3:0] phase_mask(input int lo, input int hi);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = (k >= lo) && (k <= hi);
    return m;
  endfunction

  localparam logic [3:0] WR_MASK = phase_mask(WR_FIRST, WR_LAST);
  localparam logic [3:0] OE_MASK = phase_mask(WR_FIRST, 3);

  owner_e      owner_q, owner_d;
  logic [1:0]  phase_q, phase_d;
  req_t        req_q, req_d;
  req_t        core_req, host_req_s;
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic        ncs_q, ncs_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rd_hold_q, rd_hold_d;
  logic        active_d;
  logic        host_done;

  assign core_req   = '{addr: gb_address, write: gb_write, cs: gb_chipSelect, wdata: gb_dataWrite};
  assign host_req_s = '{addr: host_address, write: host_write, cs: host_chipSelect, wdata: host_wdata};

  // A host slot completes only if it reaches the end of phase 3. If a decision
  // arrives earlier (resync), the slot is overwritten and never acknowledged.
  assign host_done = (owner_q == OWN_HOST) && (phase_q == 2'd3);

  always_comb begin
    owner_d   = owner_q;
    phase_d   = phase_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    rd_hold_d = rd_hold_q;
    ack_d     = host_done;

    if (gb_tCycle == 2'd0) begin
      phase_d = 2'd0;
      if (gb_enable) begin
        owner_d = OWN_CORE;
        req_d   = core_req;
      end else if (host_req) begin
        owner_d = OWN_HOST;
        req_d   = host_req_s;
      end else begin
        // Idle: the latched request is kept so cart_A/cart_D_out hold.
        owner_d = OWN_IDLE;
      end
    end else if (owner_q != OWN_IDLE) begin
      // Without a T-cycle 0 the slot simply runs out and the bus goes idle.
      if (phase_q == 2'd3) begin
        owner_d = OWN_IDLE;
        phase_d = 2'd0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end

    if (host_done && !req_q.write) rdata_d = cart_D_in;
    if (owner_q == OWN_CORE)       rd_hold_d = cart_D_in;

    // Pins are computed from next state so they line up with phase_q.
    active_d = (owner_d != OWN_IDLE);
    nrd_d    = !(active_d && !req_d.write);
    nwr_d    = !(active_d && req_d.write && WR_MASK[phase_d]);
    oe_d     =   active_d && req_d.write && OE_MASK[phase_d];
    ncs_d    = !(active_d && req_d.cs);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q   <= OWN_IDLE;
      phase_q   <= 2'd0;
      req_q     <= '0;
      nrd_q     <= 1'b1;
      nwr_q     <= 1'b1;
      ncs_q     <= 1'b1;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      rd_hold_q <= 8'h00;
    end else begin
      owner_q   <= owner_d;
      phase_q   <= phase_d;
      req_q     <= req_d;
      nrd_q     <= nrd_d;
      nwr_q     <= nwr_d;
      ncs_q     <= ncs_d;
      oe_q      <= oe_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  assign cart_A      = req_q.addr;
  assign cart_D_out  = req_q.wdata;
  assign cart_D_oe   = oe_q;
  assign cart_nRD    = nrd_q;
  assign cart_nWR    = nwr_q;
  assign cart_nCS    = ncs_q;
  assign host_ack    = ack_q;
  assign host_rdata  = rdata_q;
  assign slot_owner  = owner_q;
  // Core reads see the pins directly during its own slot.
  assign gb_dataRead = (owner_q == OWN_CORE) ? cart_D_in : rd_hold_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: a table of whole slots followed by
// hand-written sequences for reset mid-slot, resync and a skipped T-cycle 0.
module tb_cart_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  gb_tCycle;
  logic        gb_enable, gb_write, gb_chipSelect;
  logic [15:0] gb_address;
  logic [7:0]  gb_dataWrite, gb_dataRead;
  logic        host_req, host_write, host_chipSelect;
  logic [15:0] host_address;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] cart_A;
  logic [7:0]  cart_D_in, cart_D_out;
  logic        cart_D_oe, cart_nRD, cart_nWR, cart_nCS;
  logic [1:0]  slot_owner;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cart_bus_arbiter #(.WR_FIRST(1), .WR_LAST(2)) dut (
    .clock(clock), .reset(reset), .gb_tCycle(gb_tCycle),
    .gb_enable(gb_enable), .gb_write(gb_write), .gb_chipSelect(gb_chipSelect),
    .gb_address(gb_address), .gb_dataWrite(gb_dataWrite), .gb_dataRead(gb_dataRead),
    .host_req(host_req), .host_write(host_write), .host_chipSelect(host_chipSelect),
    .host_address(host_address), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .cart_A(cart_A), .cart_D_in(cart_D_in), .cart_D_out(cart_D_out),
    .cart_D_oe(cart_D_oe), .cart_nRD(cart_nRD), .cart_nWR(cart_nWR),
    .cart_nCS(cart_nCS), .slot_owner(slot_owner)
  );

  typedef struct {
    logic        gen, gwr, gcs;
    logic [15:0] gaddr;
    logic [7:0]  gwd;
    logic        hreq, hwr, hcs;
    logic [15:0] haddr;
    logic [7:0]  hwd;
    logic [7:0]  din;
    // expected, per slot (nwr/oe bit k = value during phase k)
    logic [1:0]  own;
    logic [15:0] a;
    logic        nrd;
    logic [3:0]  nwr;
    logic [3:0]  oe;
    logic        ncs;
    logic [7:0]  dout;
    logic [7:0]  gbrd;
    logic        ack0;   // host_ack during phase 0 (previous slot's ack)
    logic [7:0]  rd0;    // host_rdata throughout this slot
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    gb_tCycle     = 2'd0;
    gb_enable     = v.gen;   gb_write   = v.gwr;  gb_chipSelect   = v.gcs;
    gb_address    = v.gaddr; gb_dataWrite = v.gwd;
    host_req      = v.hreq;  host_write = v.hwr;  host_chipSelect = v.hcs;
    host_address  = v.haddr; host_wdata = v.hwd;
    for (int k = 0; k < 4; k++) begin
      edge1();
      gb_tCycle = 2'(k + 1);
      if (k == 0) begin
        cart_D_in = v.din;
        // core fields move mid-slot; the latched request must not
        gb_enable = 1'b1; gb_write = ~v.gwr; gb_chipSelect = ~v.gcs;
        gb_address = 16'hFFFF; gb_dataWrite = 8'hC3;
      end
      #1;
      chk($sformatf("v%0d.p%0d.owner", i, k), 16'(slot_owner), 16'(v.own));
      chk($sformatf("v%0d.p%0d.A", i, k), cart_A, v.a);
      chk($sformatf("v%0d.p%0d.nRD", i, k), 16'(cart_nRD), 16'(v.nrd));
      chk($sformatf("v%0d.p%0d.nWR", i, k), 16'(cart_nWR), 16'(v.nwr[k]));
      chk($sformatf("v%0d.p%0d.oe", i, k), 16'(cart_D_oe), 16'(v.oe[k]));
      chk($sformatf("v%0d.p%0d.nCS", i, k), 16'(cart_nCS), 16'(v.ncs));
      chk($sformatf("v%0d.p%0d.Dout", i, k), 16'(cart_D_out), 16'(v.dout));
      chk($sformatf("v%0d.p%0d.gbRead", i, k), 16'(gb_dataRead), 16'(v.gbrd));
      chk($sformatf("v%0d.p%0d.ack", i, k), 16'(host_ack), (k == 0) ? 16'(v.ack0) : 16'd0);
      chk($sformatf("v%0d.p%0d.rdata", i, k), 16'(host_rdata), 16'(v.rd0));
    end
  endtask

  initial begin
    //          gen gwr gcs gaddr     gwd    hreq hwr hcs haddr     hwd    din    own  a         nrd nwr      oe       ncs dout   gbrd   ack0 rd0
    vt[0] = '{1'b1,1'b0,1'b0,16'h0150,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 8'h11, 2'd1,16'h0150,1'b0,4'b1111,4'b0000,1'b1,8'h00,8'h11,1'b0,8'h00};
    vt[1] = '{1'b1,1'b1,1'b1,16'hA000,8'h5A, 1'b0,1'b0,1'b0,16'h0000,8'h00, 8'h22, 2'd1,16'hA000,1'b1,4'b1001,4'b1110,1'b0,8'h5A,8'h22,1'b0,8'h00};
    vt[2] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h0134,8'h00, 8'h4E, 2'd2,16'h0134,1'b0,4'b1111,4'b0000,1'b1,8'h00,8'h22,1'b0,8'h00};
    vt[3] = '{1'b1,1'b0,1'b0,16'h0200,8'h00, 1'b1,1'b1,1'b1,16'hA010,8'h33, 8'h55, 2'd1,16'h0200,1'b0,4'b1111,4'b0000,1'b1,8'h00,8'h55,1'b1,8'h4E};
    vt[4] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,1'b1,16'hA010,8'h33, 8'h66, 2'd2,16'hA010,1'b1,4'b1001,4'b1110,1'b0,8'h33,8'h55,1'b0,8'h4E};
    vt[5] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 8'h00, 2'd0,16'hA010,1'b1,4'b1111,4'b0000,1'b1,8'h33,8'h55,1'b1,8'h4E};
    vt[6] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h4000,8'h00, 8'h99, 2'd2,16'h4000,1'b0,4'b1111,4'b0000,1'b1,8'h00,8'h55,1'b0,8'h4E};
    vt[7] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h4001,8'h00, 8'h77, 2'd2,16'h4001,1'b0,4'b1111,4'b0000,1'b1,8'h00,8'h55,1'b1,8'h99};
    vt[8] = '{1'b1,1'b1,1'b0,16'h2000,8'h01, 1'b0,1'b0,1'b0,16'h0000,8'h00, 8'h3C, 2'd1,16'h2000,1'b1,4'b1001,4'b1110,1'b1,8'h01,8'h3C,1'b1,8'h77};
    vt[9] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 8'hEE, 2'd0,16'h2000,1'b1,4'b1111,4'b0000,1'b1,8'h01,8'h3C,1'b0,8'h77};

    reset = 1'b1; gb_tCycle = 2'd0;
    gb_enable = 1'b1; gb_write = 1'b0; gb_chipSelect = 1'b1;
    gb_address = 16'h1234; gb_dataWrite = 8'hAA;
    host_req = 1'b1; host_write = 1'b1; host_chipSelect = 1'b1;
    host_address = 16'h5678; host_wdata = 8'hBB; cart_D_in = 8'hCD;
    repeat (3) edge1();
    chk("rst.nRD", 16'(cart_nRD), 16'd1);
    chk("rst.nWR", 16'(cart_nWR), 16'd1);
    chk("rst.nCS", 16'(cart_nCS), 16'd1);
    chk("rst.oe", 16'(cart_D_oe), 16'd0);
    chk("rst.ack", 16'(host_ack), 16'd0);
    chk("rst.owner", 16'(slot_owner), 16'd0);
    chk("rst.A", cart_A, 16'h0000);
    chk("rst.Dout", 16'(cart_D_out), 16'd0);
    chk("rst.rdata", 16'(host_rdata), 16'd0);
    chk("rst.gbRead", 16'(gb_dataRead), 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Reset at phase 2 of a host write, then the held request reruns.
    gb_tCycle = 2'd0; gb_enable = 1'b0;
    host_req = 1'b1; host_write = 1'b1; host_chipSelect = 1'b1;
    host_address = 16'hA020; host_wdata = 8'h44;
    edge1(); gb_tCycle = 2'd1;
    chk("rw.p0.owner", 16'(slot_owner), 16'd2);
    edge1(); gb_tCycle = 2'd2;
    chk("rw.p1.nWR", 16'(cart_nWR), 16'd0);
    edge1(); gb_tCycle = 2'd3;
    chk("rw.p2.oe", 16'(cart_D_oe), 16'd1);
    reset = 1'b1;
    edge1();
    chk("rw.rst.nWR", 16'(cart_nWR), 16'd1);
    chk("rw.rst.oe", 16'(cart_D_oe), 16'd0);
    chk("rw.rst.nCS", 16'(cart_nCS), 16'd1);
    chk("rw.rst.ack", 16'(host_ack), 16'd0);
    chk("rw.rst.owner", 16'(slot_owner), 16'd0);
    reset = 1'b0; gb_tCycle = 2'd0;
    edge1(); gb_tCycle = 2'd1;
    chk("rw.re.p0.ack", 16'(host_ack), 16'd0);
    chk("rw.re.p0.owner", 16'(slot_owner), 16'd2);
    chk("rw.re.p0.A", cart_A, 16'hA020);
    edge1(); gb_tCycle = 2'd2;
    chk("rw.re.p1.nWR", 16'(cart_nWR), 16'd0);
    edge1(); gb_tCycle = 2'd3;
    edge1(); gb_tCycle = 2'd0;
    chk("rw.re.p3.nWR", 16'(cart_nWR), 16'd1);
    chk("rw.re.p3.oe", 16'(cart_D_oe), 16'd1);
    host_req = 1'b0;
    edge1(); gb_tCycle = 2'd1;
    chk("rw.re.ack", 16'(host_ack), 16'd1);
    chk("rw.re.idle", 16'(slot_owner), 16'd0);
    edge1(); gb_tCycle = 2'd2;
    chk("rw.re.ack1clk", 16'(host_ack), 16'd0);
    edge1(); gb_tCycle = 2'd3;
    edge1(); gb_tCycle = 2'd0;

    // Resync: T-cycle 0 during phase 1 of a host read aborts it.
    host_req = 1'b1; host_write = 1'b0; host_chipSelect = 1'b0;
    host_address = 16'h0300; cart_D_in = 8'hAB;
    edge1(); gb_tCycle = 2'd1;
    chk("rs.p0.owner", 16'(slot_owner), 16'd2);
    chk("rs.p0.nRD", 16'(cart_nRD), 16'd0);
    edge1(); gb_tCycle = 2'd0;
    gb_enable = 1'b1; gb_write = 1'b0; gb_chipSelect = 1'b0; gb_address = 16'h0400;
    edge1(); gb_tCycle = 2'd1;
    host_req = 1'b0; gb_enable = 1'b0;
    chk("rs.core.owner", 16'(slot_owner), 16'd1);
    chk("rs.core.A", cart_A, 16'h0400);
    chk("rs.core.ack", 16'(host_ack), 16'd0);
    edge1(); gb_tCycle = 2'd2;
    chk("rs.p1.ack", 16'(host_ack), 16'd0);
    // Skipped T-cycle 0: the core slot ends and nothing new starts.
    edge1(); gb_tCycle = 2'd3;
    chk("rs.p2.ack", 16'(host_ack), 16'd0);
    gb_enable = 1'b1;
    edge1(); gb_tCycle = 2'd1;
    chk("sk.p3.owner", 16'(slot_owner), 16'd1);
    chk("sk.p3.nRD", 16'(cart_nRD), 16'd0);
    edge1(); gb_tCycle = 2'd2;
    chk("sk.idle.owner", 16'(slot_owner), 16'd0);
    chk("sk.idle.nRD", 16'(cart_nRD), 16'd1);
    chk("sk.idle.ack", 16'(host_ack), 16'd0);
    chk("sk.rdata", 16'(host_rdata), 16'h0000);
    edge1();
    chk("sk.idle2.owner", 16'(slot_owner), 16'd0);
    chk("sk.idle2.A", cart_A, 16'h0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
